// File: rtl/ara_axi_mem_responder.sv
// AXI4 slave for the Ara wide port: serialises one burst at a time onto a
// single-ported memory that returns read data exactly one cycle after a grant.

typedef struct packed {
    logic [4:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
} axi_ara_wide_ax_t;

typedef struct packed {
    logic [127:0] data;
    logic [15:0]  strb;
    logic         last;
} axi_ara_wide_w_t;

typedef struct packed {
    logic [4:0] id;
    logic [1:0] resp;
} axi_ara_wide_b_t;

typedef struct packed {
    logic [4:0]   id;
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
} axi_ara_wide_r_t;

typedef struct packed {
    axi_ara_wide_ax_t aw;
    logic             aw_valid;
    axi_ara_wide_w_t  w;
    logic             w_valid;
    logic             b_ready;
    axi_ara_wide_ax_t ar;
    logic             ar_valid;
    logic             r_ready;
} axi_ara_wide_req_t;

typedef struct packed {
    logic            aw_ready;
    logic            ar_ready;
    logic            w_ready;
    logic            b_valid;
    axi_ara_wide_b_t b;
    logic            r_valid;
    axi_ara_wide_r_t r;
} axi_ara_wide_resp_t;

module ara_axi_mem_responder #(
    parameter int unsigned NrLanes   = 4,
    parameter int unsigned AddrWidth = 48,
    parameter type axi_req_t  = axi_ara_wide_req_t,
    parameter type axi_resp_t = axi_ara_wide_resp_t,
    localparam int unsigned DataWidth = 32 * NrLanes
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  axi_req_t               axi_req_i,
    output axi_resp_t              axi_resp_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    localparam int unsigned IdWidth  = $bits(axi_req_i.aw.id);
    localparam int unsigned OffWidth = $clog2(DataWidth / 8);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] READ       = 2'd1;
    localparam logic [1:0] WRITE      = 2'd2;
    localparam logic [1:0] WRITE_RESP = 2'd3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]           state_q, state_d;
    logic [IdWidth-1:0]   id_q;
    logic [AddrWidth-1:0] addr_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic [7:0]           beat_cnt_q;
    logic [7:0]           issue_cnt_q;
    logic                 issue_done_q;
    logic                 burst_err_q;
    logic                 wlast_err_q;
    logic                 last_write_q;
    logic                 outstanding_q;
    logic                 r_full_q;
    logic [DataWidth-1:0] r_data_q;

    logic                 pick_write, pick_read;
    logic                 aw_hs, ar_hs, w_hs, r_hs, b_hs, rd_issue;
    logic [IdWidth-1:0]   ax_id;
    logic [AddrWidth-1:0] ax_addr;
    logic [7:0]           ax_len;
    logic [2:0]           ax_size;
    logic [1:0]           ax_burst;
    logic [AddrWidth-1:0] next_addr;

    // A contested IDLE cycle goes to the type not served last; after reset
    // "last" is read, so a write wins the first contest.
    always_comb begin
        pick_write = axi_req_i.aw_valid && (!axi_req_i.ar_valid || !last_write_q);
        pick_read  = axi_req_i.ar_valid && !pick_write;
        ax_id      = aw_hs ? axi_req_i.aw.id    : axi_req_i.ar.id;
        ax_addr    = aw_hs ? axi_req_i.aw.addr  : axi_req_i.ar.addr;
        ax_len     = aw_hs ? axi_req_i.aw.len   : axi_req_i.ar.len;
        ax_size    = aw_hs ? axi_req_i.aw.size  : axi_req_i.ar.size;
        ax_burst   = aw_hs ? axi_req_i.aw.burst : axi_req_i.ar.burst;
        next_addr  = (burst_q == BURST_FIXED) ? addr_q : addr_q + (AddrWidth'(1) << size_q);
    end

    always_comb begin
        axi_resp_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {addr_q[AddrWidth-1:OffWidth], {OffWidth{1'b0}}};
        mem_wdata_o = axi_req_i.w.data;
        mem_be_o    = axi_req_i.w.strb;
        case (state_q)
            IDLE: begin
                axi_resp_o.aw_ready = rst_ni && pick_write;
                axi_resp_o.ar_ready = rst_ni && pick_read;
            end
            READ: begin
                axi_resp_o.r_valid = burst_err_q || r_full_q;
                axi_resp_o.r.id    = id_q;
                axi_resp_o.r.data  = burst_err_q ? '0 : r_data_q;
                axi_resp_o.r.resp  = burst_err_q ? RESP_SLVERR : RESP_OKAY;
                axi_resp_o.r.last  = (beat_cnt_q == '0);
                // Only one read in flight, and only when its data has a free slot.
                mem_req_o = !burst_err_q && !issue_done_q && !outstanding_q &&
                            (!r_full_q || axi_req_i.r_ready);
            end
            WRITE: begin
                mem_req_o          = !burst_err_q && axi_req_i.w_valid;
                mem_we_o           = 1'b1;
                axi_resp_o.w_ready = burst_err_q || mem_gnt_i;
            end
            WRITE_RESP: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b.id    = id_q;
                axi_resp_o.b.resp  = (burst_err_q || wlast_err_q) ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    always_comb begin
        aw_hs    = axi_req_i.aw_valid && axi_resp_o.aw_ready;
        ar_hs    = axi_req_i.ar_valid && axi_resp_o.ar_ready;
        w_hs     = axi_req_i.w_valid  && axi_resp_o.w_ready;
        r_hs     = axi_resp_o.r_valid && axi_req_i.r_ready;
        b_hs     = axi_resp_o.b_valid && axi_req_i.b_ready;
        rd_issue = (state_q == READ) && mem_req_o && mem_gnt_i;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (aw_hs) state_d = WRITE; else if (ar_hs) state_d = READ;
            READ:       if (r_hs && beat_cnt_q == '0) state_d = IDLE;
            WRITE:      if (w_hs && beat_cnt_q == '0) state_d = WRITE_RESP;
            WRITE_RESP: if (b_hs) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            id_q          <= '0;
            addr_q        <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            beat_cnt_q    <= '0;
            issue_cnt_q   <= '0;
            issue_done_q  <= 1'b0;
            burst_err_q   <= 1'b0;
            wlast_err_q   <= 1'b0;
            last_write_q  <= 1'b0;
            outstanding_q <= 1'b0;
            r_full_q      <= 1'b0;
            r_data_q      <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= rd_issue;
            if (aw_hs || ar_hs) begin
                id_q         <= ax_id;
                addr_q       <= ax_addr;
                size_q       <= ax_size;
                burst_q      <= ax_burst;
                beat_cnt_q   <= ax_len;
                issue_cnt_q  <= ax_len;
                issue_done_q <= 1'b0;
                // WRAP and the reserved encoding both have bit 1 set.
                burst_err_q  <= ax_burst[1];
                wlast_err_q  <= 1'b0;
                last_write_q <= aw_hs;
                r_full_q     <= 1'b0;
            end
            if (rd_issue) begin
                addr_q      <= next_addr;
                issue_cnt_q <= issue_cnt_q - 8'd1;
                if (issue_cnt_q == '0) issue_done_q <= 1'b1;
            end
            if (outstanding_q && mem_rvalid_i) begin
                r_data_q <= mem_rdata_i;
                r_full_q <= 1'b1;
            end else if (r_hs) begin
                r_full_q <= 1'b0;
            end
            if (r_hs && beat_cnt_q != '0) beat_cnt_q <= beat_cnt_q - 8'd1;
            if (w_hs) begin
                addr_q <= next_addr;
                if (beat_cnt_q != '0) beat_cnt_q <= beat_cnt_q - 8'd1;
                if (axi_req_i.w.last != (beat_cnt_q == '0)) wlast_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ara_axi_mem_responder.sv
// Directed bench for ara_axi_mem_responder with a one-cycle-latency memory model.

module tb_ara_axi_mem_responder;

    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] WRAP = 2'b10;

    logic               clk = 1'b0;
    logic               rst_n;
    axi_ara_wide_req_t  req;
    axi_ara_wide_resp_t resp;
    logic               mem_req, gnt, we, rvalid;
    logic [47:0]        maddr;
    logic [127:0]       wdata, rdata;
    logic [15:0]        be;

    logic [47:0]  rd_addr_q[$];
    logic [47:0]  wr_addr_q[$];
    logic [15:0]  wr_be_q[$];
    logic [127:0] wr_data_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    ara_axi_mem_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .axi_req_i   (req),
        .axi_resp_o  (resp),
        .mem_req_o   (mem_req),
        .mem_gnt_i   (gnt),
        .mem_we_o    (we),
        .mem_addr_o  (maddr),
        .mem_wdata_o (wdata),
        .mem_be_o    (be),
        .mem_rvalid_i(rvalid),
        .mem_rdata_i (rdata)
    );

    always #5 clk = ~clk;

    // Memory returns the beat address replicated in every lane.
    always @(posedge clk) begin
        rvalid <= mem_req && gnt && !we;
        rdata  <= {4{maddr[31:0]}};
        if (mem_req && gnt) begin
            if (we) begin
                wr_addr_q.push_back(maddr);
                wr_be_q.push_back(be);
                wr_data_q.push_back(wdata);
            end else begin
                rd_addr_q.push_back(maddr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_ar(input logic [4:0] a_id, input logic [47:0] a_addr,
                            input logic [7:0] a_len, input logic [1:0] a_burst);
        int n = 0;
        req.ar = '{id: a_id, addr: a_addr, len: a_len, size: 3'd4, burst: a_burst};
        req.ar_valid = 1'b1;
        #1;
        while (!resp.ar_ready && n < 20) begin tick(); n++; end
        tests_run++;
        if (resp.ar_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL ar_accept: ar_ready=%b required 1", resp.ar_ready); end
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic issue_aw(input logic [4:0] a_id, input logic [47:0] a_addr,
                            input logic [7:0] a_len, input logic [1:0] a_burst);
        int n = 0;
        req.aw = '{id: a_id, addr: a_addr, len: a_len, size: 3'd4, burst: a_burst};
        req.aw_valid = 1'b1;
        #1;
        while (!resp.aw_ready && n < 20) begin tick(); n++; end
        tests_run++;
        if (resp.aw_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL aw_accept: aw_ready=%b required 1", resp.aw_ready); end
        tick();
        req.aw_valid = 1'b0;
    endtask

    task automatic test_reset();
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        #1;
        tests_run += 5;
        if (resp.aw_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_aw_ready: got %b required 0", resp.aw_ready); end
        if (resp.ar_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_ar_ready: got %b required 0", resp.ar_ready); end
        if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mem_req: got %b required 0", mem_req); end
        if (resp.r_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_r_valid: got %b required 0", resp.r_valid); end
        if (resp.b_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_b_valid: got %b required 0", resp.b_valid); end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        tests_run += 2;
        if (resp.aw_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rel_aw_ready: got %b required 1", resp.aw_ready); end
        if (resp.ar_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rel_ar_ready: got %b required 0", resp.ar_ready); end
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        tick();
    endtask

    task automatic test_incr_read();
        logic [31:0] exp_addr [4] = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
        int base = rd_addr_q.size();
        int beats = 0, cyc = 0, prev = 0;
        req.r_ready = 1'b1;
        issue_ar(5'd3, 48'h1000, 8'd3, INCR);
        while (beats < 4 && cyc < 40) begin
            if (resp.r_valid) begin
                tests_run += 4;
                if (resp.r.data !== {4{exp_addr[beats]}}) begin tests_failed++; $display("[TB] FAIL rd_data beat %0d: got %h required %h", beats, resp.r.data, {4{exp_addr[beats]}}); end
                if (resp.r.resp !== 2'b00 || resp.r.id !== 5'd3) begin tests_failed++; $display("[TB] FAIL rd_resp_id beat %0d: got %b/%0d required 00/3", beats, resp.r.resp, resp.r.id); end
                if (resp.r.last !== (beats == 3)) begin tests_failed++; $display("[TB] FAIL rd_last beat %0d: got %b required %b", beats, resp.r.last, beats == 3); end
                if (beats > 0 && cyc - prev != 2) begin tests_failed++; $display("[TB] FAIL rd_spacing beat %0d: got %0d required 2", beats, cyc - prev); end
                beats++;
                prev = cyc;
            end
            tick();
            cyc++;
        end
        tests_run += 2;
        if (beats != 4) begin tests_failed++; $display("[TB] FAIL rd_beats: got %0d required 4", beats); end
        if (rd_addr_q.size() - base != 4) begin tests_failed++; $display("[TB] FAIL rd_mem_count: got %0d required 4", rd_addr_q.size() - base); end
        else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (rd_addr_q[base + i] !== {16'h0, exp_addr[i]}) begin tests_failed++; $display("[TB] FAIL rd_mem_addr %0d: got %h required %h", i, rd_addr_q[base + i], exp_addr[i]); end
            end
        end
    endtask

    task automatic test_write_stall();
        int base = wr_addr_q.size();
        req.b_ready = 1'b0;
        gnt = 1'b1;
        issue_aw(5'd5, 48'h2000, 8'd1, INCR);
        req.w = '{data: {4{32'hCAFE_0000}}, strb: 16'hFFFF, last: 1'b0};
        req.w_valid = 1'b1;
        gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run += 2;
            if (resp.w_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_w_ready %0d: got %b required 0", i, resp.w_ready); end
            if (mem_req !== 1'b1 || we !== 1'b1 || maddr !== 48'h2000) begin tests_failed++; $display("[TB] FAIL stall_hold %0d: req=%b we=%b addr=%h required 1/1/2000", i, mem_req, we, maddr); end
            tick();
        end
        gnt = 1'b1;
        #1;
        tests_run++;
        if (resp.w_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL gnt_w_ready: got %b required 1", resp.w_ready); end
        tick();
        req.w = '{data: {4{32'hBEEF_0001}}, strb: 16'h00FF, last: 1'b1};
        tick();
        req.w_valid = 1'b0;
        tests_run++;
        if (resp.b_valid !== 1'b1 || resp.b.id !== 5'd5 || resp.b.resp !== 2'b00) begin tests_failed++; $display("[TB] FAIL wr_b: valid=%b id=%0d resp=%b required 1/5/00", resp.b_valid, resp.b.id, resp.b.resp); end
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        tests_run += 2;
        if (resp.b_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_b_drop: got %b required 0", resp.b_valid); end
        if (wr_addr_q.size() - base != 2) begin tests_failed++; $display("[TB] FAIL wr_count: got %0d required 2", wr_addr_q.size() - base); end
        else begin
            tests_run += 2;
            if (wr_addr_q[base] !== 48'h2000 || wr_be_q[base] !== 16'hFFFF || wr_data_q[base] !== {4{32'hCAFE_0000}}) begin tests_failed++; $display("[TB] FAIL wr_beat0: addr=%h be=%h required 2000/ffff", wr_addr_q[base], wr_be_q[base]); end
            if (wr_addr_q[base+1] !== 48'h2010 || wr_be_q[base+1] !== 16'h00FF || wr_data_q[base+1] !== {4{32'hBEEF_0001}}) begin tests_failed++; $display("[TB] FAIL wr_beat1: addr=%h be=%h required 2010/00ff", wr_addr_q[base+1], wr_be_q[base+1]); end
        end
    endtask

    task automatic test_arbitration();
        int cyc = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        gnt = 1'b1;
        req.r_ready = 1'b1;
        req.b_ready = 1'b1;
        req.aw = '{id: 5'd1, addr: 48'h6000, len: 8'd0, size: 3'd4, burst: INCR};
        req.ar = '{id: 5'd2, addr: 48'h7000, len: 8'd0, size: 3'd4, burst: INCR};
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        #1;
        tests_run++;
        if (resp.aw_ready !== 1'b1 || resp.ar_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL arb_first: aw/ar ready=%b%b required 10", resp.aw_ready, resp.ar_ready); end
        tick();
        req.aw_valid = 1'b0;
        req.w = '{data: '0, strb: 16'hFFFF, last: 1'b1};
        req.w_valid = 1'b1;
        #1;
        tests_run++;
        if (resp.ar_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL arb_busy_ar: got %b required 0", resp.ar_ready); end
        tick();
        req.w_valid = 1'b0;
        tests_run++;
        if (resp.b_valid !== 1'b1 || resp.b.id !== 5'd1) begin tests_failed++; $display("[TB] FAIL arb_b: valid=%b id=%0d required 1/1", resp.b_valid, resp.b.id); end
        tick();
        req.aw_valid = 1'b1;
        #1;
        tests_run++;
        if (resp.aw_ready !== 1'b0 || resp.ar_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL arb_second: aw/ar ready=%b%b required 01", resp.aw_ready, resp.ar_ready); end
        tick();
        req.ar_valid = 1'b0;
        while (!resp.r_valid && cyc < 10) begin
            tests_run++;
            if (resp.aw_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL arb_busy_aw: got %b required 0", resp.aw_ready); end
            tick();
            cyc++;
        end
        tests_run++;
        if (resp.r_valid !== 1'b1 || resp.r.id !== 5'd2 || resp.r.data !== {4{32'h7000}}) begin tests_failed++; $display("[TB] FAIL arb_read: valid=%b id=%0d data=%h required 1/2/7000..", resp.r_valid, resp.r.id, resp.r.data); end
        tick();
        #1;
        tests_run++;
        if (resp.aw_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL arb_then_write: got %b required 1", resp.aw_ready); end
        tick();
        req.aw_valid = 1'b0;
        req.w_valid = 1'b1;
        tick();
        req.w_valid = 1'b0;
        tick();
        req.b_ready = 1'b0;
    endtask

    task automatic test_wrap_read();
        int beats = 0, cyc = 0, prev = 0;
        logic seen = 1'b0;
        req.r_ready = 1'b1;
        issue_ar(5'd7, 48'h3000, 8'd2, WRAP);
        while (beats < 3 && cyc < 20) begin
            if (mem_req) seen = 1'b1;
            if (resp.r_valid) begin
                tests_run += 3;
                if (resp.r.resp !== 2'b10 || resp.r.data !== '0) begin tests_failed++; $display("[TB] FAIL wrap_resp beat %0d: resp=%b data=%h required 10/0", beats, resp.r.resp, resp.r.data); end
                if (resp.r.last !== (beats == 2)) begin tests_failed++; $display("[TB] FAIL wrap_last beat %0d: got %b required %b", beats, resp.r.last, beats == 2); end
                if (beats > 0 && cyc != prev + 1) begin tests_failed++; $display("[TB] FAIL wrap_spacing beat %0d: got %0d required 1", beats, cyc - prev); end
                beats++;
                prev = cyc;
            end
            tick();
            cyc++;
        end
        tests_run += 3;
        if (beats != 3) begin tests_failed++; $display("[TB] FAIL wrap_beats: got %0d required 3", beats); end
        if (seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_mem_req: got %b required 0", seen); end
        if (resp.r_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_idle: r_valid=%b required 0", resp.r_valid); end
    endtask

    task automatic test_wlast_err();
        int w_beats = 0, cyc = 0;
        gnt = 1'b1;
        req.b_ready = 1'b0;
        issue_aw(5'd9, 48'h8000, 8'd2, INCR);
        while (!resp.b_valid && cyc < 20) begin
            req.w = '{data: 128'(w_beats), strb: 16'hFFFF, last: (w_beats >= 1)};
            req.w_valid = 1'b1;
            #1;
            if (resp.w_ready) w_beats++;
            tick();
            cyc++;
        end
        req.w_valid = 1'b0;
        tests_run += 2;
        if (w_beats != 3) begin tests_failed++; $display("[TB] FAIL wlast_beats: got %0d required 3", w_beats); end
        if (resp.b_valid !== 1'b1 || resp.b.resp !== 2'b10 || resp.b.id !== 5'd9) begin tests_failed++; $display("[TB] FAIL wlast_b: valid=%b resp=%b id=%0d required 1/10/9", resp.b_valid, resp.b.resp, resp.b.id); end
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int cyc = 0;
        req.r_ready = 1'b0;
        issue_ar(5'd4, 48'h4000, 8'd3, INCR);
        while (!resp.r_valid && cyc < 20) begin tick(); cyc++; end
        tests_run++;
        if (resp.r_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_r_valid: got %b required 1", resp.r_valid); end
        rst_n = 1'b0;
        #1;
        tests_run += 2;
        if (resp.r_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_r_valid: got %b required 0", resp.r_valid); end
        if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_mem_req: got %b required 0", mem_req); end
        tick();
        tick();
        rst_n = 1'b1;
        req.r_ready = 1'b1;
        issue_ar(5'd6, 48'h5000, 8'd0, INCR);
        cyc = 0;
        while (!resp.r_valid && cyc < 20) begin tick(); cyc++; end
        tests_run++;
        if (resp.r_valid !== 1'b1 || resp.r.data !== {4{32'h5000}} || resp.r.id !== 5'd6 || resp.r.last !== 1'b1 || resp.r.resp !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL post_rst_read: valid=%b id=%0d last=%b resp=%b data=%h", resp.r_valid, resp.r.id, resp.r.last, resp.r.resp, resp.r.data);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        req   = '0;
        gnt   = 1'b1;
        rst_n = 1'b0;
        test_reset();
        test_incr_read();
        test_write_stall();
        test_arbitration();
        test_wrap_read();
        test_wlast_err();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
